l1_bus_arb: RTL and testbench

- Arbitrates the single hart-to-memory line bus between L1 instruction-cache refills and L1 data-cache refills/writebacks.
- Sits between imem/dmem and the memory bus.
- Latches one whole-line request per transaction and runs it to completion.
- Returns data to the owner with a one-cycle valid pulse, and aborts hung transactions via a watchdog.

---
 rtl/l1_bus_arb_pkg.sv | 31 +++
 rtl/l1_bus_arb_if.sv | 36 +++
 rtl/l1_bus_wdog.sv | 38 +++
 rtl/l1_bus_arb.sv | 127 ++++++++++++
 tb/tb_l1_bus_arb.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_bus_arb_pkg.sv
// Shared configuration and encodings for the L1 line-bus arbiter.
// Line geometry defaults follow the imem configuration macros when present.
`ifndef IMEM_LINE
`define IMEM_LINE 256
`endif
`ifndef IMEM_OFFS_LEN
`define IMEM_OFFS_LEN 5
`endif

package l1_bus_arb_pkg;

   localparam int unsigned LINE_DEF    = `IMEM_LINE;
   localparam int unsigned OFFS_DEF    = `IMEM_OFFS_LEN;
   localparam int unsigned TIMEOUT_DEF = 1024;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } state_e;

   function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned offs);
      return addr & ~((64'd1 << offs) - 64'd1);
   endfunction

endpackage

// File: rtl/l1_bus_arb_if.sv
// L1 refill/writeback request channels plus the memory line bus, as seen by the arbiter.
// master is the arbiter side; slave is the caches-and-memory side.
interface l1_bus_arb_if
   import l1_bus_arb_pkg::*;
#(
   parameter int unsigned LINE = LINE_DEF
);
   logic [63:0]     i_addr;
   logic            i_rd;
   logic [LINE-1:0] i_data;
   logic            i_dv;
   logic [63:0]     d_addr;
   logic            d_rd;
   logic            d_wr;
   logic [LINE-1:0] d_wdata;
   logic [LINE-1:0] d_data;
   logic            d_dv;
   logic [63:0]     m_addr;
   logic            m_rd;
   logic            m_wr;
   logic [LINE-1:0] m_wdata;
   logic [LINE-1:0] m_rdata;
   logic            m_dv;
   logic            to_err;
   logic            busy;

   modport master (
      input  i_addr, i_rd, d_addr, d_rd, d_wr, d_wdata, m_rdata, m_dv,
      output i_data, i_dv, d_data, d_dv, m_addr, m_rd, m_wr, m_wdata, to_err, busy
   );

   modport slave (
      output i_addr, i_rd, d_addr, d_rd, d_wr, d_wdata, m_rdata, m_dv,
      input  i_data, i_dv, d_data, d_dv, m_addr, m_rd, m_wr, m_wdata, to_err, busy
   );
endinterface

// File: rtl/l1_bus_wdog.sv
// Bus-phase watchdog: counts enabled cycles and flags the cycle that reaches TIMEOUT.
// TIMEOUT of 0 disables expiry.
module l1_bus_wdog
   import l1_bus_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int unsigned W = $clog2(TIMEOUT + 2);
   localparam logic [W-1:0] LAST = (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   // Expires on the TIMEOUT-th enabled cycle, so the count never needs to reach TIMEOUT itself.
   assign expire = (TIMEOUT != 0) && en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expire) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/l1_bus_arb.sv
// Round-robin arbiter sharing one whole-line memory bus between imem refills and dmem
// refills/writebacks; one latched transaction at a time, guarded by a watchdog.
module l1_bus_arb
   import l1_bus_arb_pkg::*;
#(
   parameter int unsigned LINE    = LINE_DEF,
   parameter int unsigned OFFS    = $clog2(LINE / 8),
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input logic          clk,
   input logic          rst_n,
   l1_bus_arb_if.master bus
);
   state_e          state_q, state_d;
   owner_e          owner_q, owner_d;
   owner_e          rr_last_q, rr_last_d;
   logic            op_wr_q, op_wr_d;
   logic [63:0]     addr_q, addr_d;
   logic [LINE-1:0] wdata_q, wdata_d;
   logic [LINE-1:0] i_data_q, i_data_d;
   logic [LINE-1:0] d_data_q, d_data_d;
   logic            i_dv_q, i_dv_d;
   logic            d_dv_q, d_dv_d;
   logic            to_err_q, to_err_d;
   logic            i_req, d_req, pick_d, i_match, wd_expire;

   l1_bus_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state_q == IDLE),
      .en     (state_q == BUS),
      .expire (wd_expire)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_last_d = rr_last_q;
      op_wr_d   = op_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_data_d  = i_data_q;
      d_data_d  = d_data_q;
      i_dv_d    = 1'b0;
      d_dv_d    = 1'b0;
      to_err_d  = 1'b0;

      i_req   = bus.i_rd;
      d_req   = bus.d_rd | bus.d_wr;
      pick_d  = d_req && (!i_req || (rr_last_q == OWN_I));
      // imem only gets its data if it still wants this very line.
      i_match = bus.i_rd && (bus.i_addr[63:OFFS] == addr_q[63:OFFS]);

      unique case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               state_d = BUS;
               owner_d = pick_d ? OWN_D : OWN_I;
               addr_d  = line_align(pick_d ? bus.d_addr : bus.i_addr, OFFS);
               op_wr_d = pick_d && bus.d_wr;
               wdata_d = bus.d_wdata;
            end
         end
         BUS: begin
            if (bus.m_dv) begin
               state_d   = RESP;
               rr_last_d = owner_q;
               if (owner_q == OWN_I) begin
                  i_data_d = bus.m_rdata;
                  i_dv_d   = i_match;
               end else begin
                  if (!op_wr_q) begin
                     d_data_d = bus.m_rdata;
                  end
                  d_dv_d = 1'b1;
               end
            end else if (wd_expire) begin
               state_d  = IDLE;
               to_err_d = 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= OWN_I;
         rr_last_q <= OWN_D;
         op_wr_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_data_q  <= '0;
         d_data_q  <= '0;
         i_dv_q    <= 1'b0;
         d_dv_q    <= 1'b0;
         to_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_last_q <= rr_last_d;
         op_wr_q   <= op_wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_data_q  <= i_data_d;
         d_data_q  <= d_data_d;
         i_dv_q    <= i_dv_d;
         d_dv_q    <= d_dv_d;
         to_err_q  <= to_err_d;
      end
   end

   assign bus.m_rd    = (state_q == BUS) && !op_wr_q;
   assign bus.m_wr    = (state_q == BUS) && op_wr_q;
   assign bus.m_addr  = addr_q;
   assign bus.m_wdata = wdata_q;
   assign bus.i_data  = i_data_q;
   assign bus.i_dv    = i_dv_q;
   assign bus.d_data  = d_data_q;
   assign bus.d_dv    = d_dv_q;
   assign bus.to_err  = to_err_q;
   assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_l1_bus_arb.sv
// Directed bench for l1_bus_arb: single refill, contention, writeback precedence,
// stale imem, watchdog expiry and reset mid-transaction.
module tb_l1_bus_arb;
   localparam int unsigned LINE = 256;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   l1_bus_arb_if #(.LINE(LINE)) bus ();

   l1_bus_arb #(
      .LINE    (LINE),
      .TIMEOUT (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [LINE-1:0] PAT_A = {8{32'hA5A5_0001}};
   localparam logic [LINE-1:0] PAT_B = {8{32'hB0B0_0002}};
   localparam logic [LINE-1:0] PAT_C1 = {8{32'hC1C1_0003}};
   localparam logic [LINE-1:0] PAT_C2 = {8{32'hC2C2_0004}};
   localparam logic [LINE-1:0] PAT_C3 = {8{32'hC3C3_0005}};
   localparam logic [LINE-1:0] PAT_C4 = {8{32'hC4C4_0006}};
   localparam logic [LINE-1:0] PAT_C5 = {8{32'hC5C5_0007}};
   localparam logic [LINE-1:0] PAT_C6 = {8{32'hC6C6_0008}};
   localparam logic [LINE-1:0] PAT_C7 = {8{32'hC7C7_0009}};
   localparam logic [LINE-1:0] PAT_X = {8{32'hDEAD_BEEF}};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LINE-1:0] obs, input logic [LINE-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, ".m_rd"}, LINE'(bus.m_rd), '0);
      chk({tag, ".m_wr"}, LINE'(bus.m_wr), '0);
      chk({tag, ".i_dv"}, LINE'(bus.i_dv), '0);
      chk({tag, ".d_dv"}, LINE'(bus.d_dv), '0);
      chk({tag, ".to_err"}, LINE'(bus.to_err), '0);
      chk({tag, ".busy"}, LINE'(bus.busy), '0);
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.i_addr  = '0;
      bus.i_rd    = 1'b0;
      bus.d_addr  = '0;
      bus.d_rd    = 1'b0;
      bus.d_wr    = 1'b0;
      bus.d_wdata = '0;
      bus.m_rdata = '0;
      bus.m_dv    = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      chk_idle_outs("rst");
      chk("rst.m_addr", LINE'(bus.m_addr), '0);
      chk("rst.i_data", bus.i_data, '0);
      chk("rst.d_data", bus.d_data, '0);

      // Single imem request: N = this cycle
      bus.i_rd   = 1'b1;
      bus.i_addr = 64'h1234;
      tick();                                            // N+1
      chk("t1.m_rd", LINE'(bus.m_rd), LINE'(1));
      chk("t1.m_wr", LINE'(bus.m_wr), '0);
      chk("t1.m_addr", LINE'(bus.m_addr), LINE'(64'h1220));
      chk("t1.busy", LINE'(bus.busy), LINE'(1));
      tick();                                            // N+2
      chk("t1.m_rd2", LINE'(bus.m_rd), LINE'(1));
      tick();                                            // N+3
      chk("t1.i_dv_early", LINE'(bus.i_dv), '0);
      tick();                                            // N+4
      chk("t1.m_rd4", LINE'(bus.m_rd), LINE'(1));
      chk("t1.m_addr4", LINE'(bus.m_addr), LINE'(64'h1220));
      bus.m_dv    = 1'b1;
      bus.m_rdata = PAT_A;
      tick();                                            // N+5
      bus.m_dv = 1'b0;
      chk("t1.i_dv", LINE'(bus.i_dv), LINE'(1));
      chk("t1.i_data", bus.i_data, PAT_A);
      chk("t1.d_dv", LINE'(bus.d_dv), '0);
      chk("t1.m_rd_resp", LINE'(bus.m_rd), '0);
      bus.i_rd = 1'b0;
      tick();                                            // N+6
      chk("t1.i_dv_once", LINE'(bus.i_dv), '0);
      chk("t1.busy_end", LINE'(bus.busy), '0);

      // Contention from reset: I, D, I
      rst_n = 1'b0;
      tick();
      rst_n      = 1'b1;
      bus.i_rd   = 1'b1;
      bus.i_addr = 64'h1000;
      bus.d_rd   = 1'b1;
      bus.d_addr = 64'h2000;
      tick();
      chk("t2.g1_addr", LINE'(bus.m_addr), LINE'(64'h1000));
      chk("t2.g1_rd", LINE'(bus.m_rd), LINE'(1));
      bus.m_dv    = 1'b1;
      bus.m_rdata = PAT_C1;
      tick();
      bus.m_dv = 1'b0;
      chk("t2.g1_i_dv", LINE'(bus.i_dv), LINE'(1));
      chk("t2.g1_i_data", bus.i_data, PAT_C1);
      chk("t2.g1_d_dv", LINE'(bus.d_dv), '0);
      tick();
      chk("t2.idle_gap", LINE'(bus.busy), '0);
      tick();
      chk("t2.g2_addr", LINE'(bus.m_addr), LINE'(64'h2000));
      chk("t2.g2_rd", LINE'(bus.m_rd), LINE'(1));
      bus.m_dv    = 1'b1;
      bus.m_rdata = PAT_C2;
      tick();
      bus.m_dv = 1'b0;
      chk("t2.g2_d_dv", LINE'(bus.d_dv), LINE'(1));
      chk("t2.g2_d_data", bus.d_data, PAT_C2);
      chk("t2.g2_i_dv", LINE'(bus.i_dv), '0);
      bus.d_rd = 1'b0;
      tick();
      tick();
      chk("t2.g3_addr", LINE'(bus.m_addr), LINE'(64'h1000));
      bus.m_dv    = 1'b1;
      bus.m_rdata = PAT_C3;
      tick();
      bus.m_dv = 1'b0;
      chk("t2.g3_i_dv", LINE'(bus.i_dv), LINE'(1));
      chk("t2.g3_i_data", bus.i_data, PAT_C3);
      bus.i_rd = 1'b0;
      tick();

      // Writeback precedence over refill
      bus.d_wr    = 1'b1;
      bus.d_rd    = 1'b1;
      bus.d_addr  = 64'h305F;
      bus.d_wdata = PAT_B;
      tick();
      chk("t3.wr", LINE'(bus.m_wr), LINE'(1));
      chk("t3.rd", LINE'(bus.m_rd), '0);
      chk("t3.wdata", bus.m_wdata, PAT_B);
      chk("t3.addr", LINE'(bus.m_addr), LINE'(64'h3040));
      bus.m_dv    = 1'b1;
      bus.m_rdata = PAT_X;
      tick();
      bus.m_dv = 1'b0;
      chk("t3.wr_d_dv", LINE'(bus.d_dv), LINE'(1));
      chk("t3.wr_d_data", bus.d_data, PAT_C2);
      bus.d_wr = 1'b0;
      tick();
      tick();
      chk("t3.rd2", LINE'(bus.m_rd), LINE'(1));
      chk("t3.wr2", LINE'(bus.m_wr), '0);
      bus.m_dv    = 1'b1;
      bus.m_rdata = PAT_C4;
      tick();
      bus.m_dv = 1'b0;
      chk("t3.rd_d_dv", LINE'(bus.d_dv), LINE'(1));
      chk("t3.rd_d_data", bus.d_data, PAT_C4);
      bus.d_rd = 1'b0;
      tick();

      // Stale imem: request withdrawn after grant
      bus.i_rd   = 1'b1;
      bus.i_addr = 64'h4000;
      tick();
      chk("t4.rd", LINE'(bus.m_rd), LINE'(1));
      bus.i_rd = 1'b0;
      tick();
      tick();
      bus.m_dv    = 1'b1;
      bus.m_rdata = PAT_C5;
      tick();
      bus.m_dv = 1'b0;
      chk("t4.no_i_dv", LINE'(bus.i_dv), '0);
      chk("t4.no_d_dv", LINE'(bus.d_dv), '0);
      tick();
      bus.i_rd   = 1'b1;
      bus.i_addr = 64'h5000;
      tick();
      chk("t4.next_addr", LINE'(bus.m_addr), LINE'(64'h5000));
      bus.m_dv    = 1'b1;
      bus.m_rdata = PAT_C6;
      tick();
      bus.m_dv = 1'b0;
      chk("t4.next_i_dv", LINE'(bus.i_dv), LINE'(1));
      chk("t4.next_i_data", bus.i_data, PAT_C6);
      bus.i_rd = 1'b0;
      tick();

      // Watchdog expiry (TIMEOUT=8), then retry with m_dv on the expiry cycle
      bus.i_rd   = 1'b1;
      bus.i_addr = 64'h6000;
      tick();                                            // N+1
      for (int k = 2; k <= 8; k++) begin
         chk("t5.pre_err", LINE'(bus.to_err), '0);
         tick();                                         // N+k
      end
      chk("t5.rd_last", LINE'(bus.m_rd), LINE'(1));
      tick();                                            // N+9
      chk("t5.to_err", LINE'(bus.to_err), LINE'(1));
      chk("t5.rd_drop", LINE'(bus.m_rd), '0);
      chk("t5.no_dv", LINE'(bus.i_dv), '0);
      tick();                                            // regranted, first BUS cycle
      chk("t5.err_once", LINE'(bus.to_err), '0);
      chk("t5.regrant", LINE'(bus.m_rd), LINE'(1));
      for (int k = 2; k <= 8; k++) begin
         tick();
      end
      bus.m_dv    = 1'b1;
      bus.m_rdata = PAT_C7;
      tick();
      bus.m_dv = 1'b0;
      chk("t5.race_dv", LINE'(bus.i_dv), LINE'(1));
      chk("t5.race_data", bus.i_data, PAT_C7);
      chk("t5.race_no_err", LINE'(bus.to_err), '0);
      bus.i_rd = 1'b0;
      tick();
      chk("t5.race_no_err2", LINE'(bus.to_err), '0);

      // Reset during BUS drops the transaction
      bus.i_rd   = 1'b1;
      bus.i_addr = 64'h7000;
      tick();
      tick();
      chk("t6.in_bus", LINE'(bus.busy), LINE'(1));
      rst_n = 1'b0;
      tick();
      chk_idle_outs("t6.rst");
      chk("t6.m_addr", LINE'(bus.m_addr), '0);
      chk("t6.i_data", bus.i_data, '0);
      chk("t6.d_data", bus.d_data, '0);
      rst_n       = 1'b1;
      bus.i_rd    = 1'b0;
      bus.m_dv    = 1'b1;
      bus.m_rdata = PAT_X;
      tick();
      bus.m_dv = 1'b0;
      chk_idle_outs("t6.late");
      tick();
      chk_idle_outs("t6.after");
      chk("t6.i_data_after", bus.i_data, '0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
